// File: rtl/dac_ad56x4_pkg.sv
// ============================================================================
// Module   : dac_ad56x4_pkg
// Purpose  : Shared constants, register map and FSM states for the AD56x4 driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_ad56x4_pkg;

  localparam int FRAME_W = 24;

  localparam logic [2:0] CMD_WR_IN  = 3'b000;
  localparam logic [2:0] CMD_UPD    = 3'b001;
  localparam logic [2:0] CMD_WR_UPD = 3'b011;
  localparam logic [2:0] ADDR_ALL   = 3'b111;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_CH_EN     = 3'd1;
  localparam logic [2:0] REG_SIGNED    = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_FRAME_CNT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dac_spi_serializer.sv
// ============================================================================
// Module   : dac_spi_serializer
// Purpose  : Shifts one 24-bit frame out on SYNC/SCLK/DIN, then enforces the SYNC-high gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_spi_serializer
  import dac_ad56x4_pkg::*;
#(
  parameter int SCLK_DIVIDER  = 2,
  parameter int SYNC_DURATION = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sync_o,
  output logic               sclk_o,
  output logic               din_o
);

  localparam int DIV_W = $clog2(SCLK_DIVIDER + 1);
  localparam int GAP_W = $clog2(SYNC_DURATION + 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [5:0]         half_q, half_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               sync_q, sync_d, sclk_q, sclk_d, din_q, din_d;
  logic               div_end;

  assign div_end = (div_q == DIV_W'(SCLK_DIVIDER - 1));
  // A new frame may start on the last gap cycle so SYNC stays high exactly SYNC_DURATION clk.
  assign ready_o = (state_q == ST_IDLE) ||
                   ((state_q == ST_GAP) && (gap_q == GAP_W'(SYNC_DURATION - 1)));
  assign busy_o  = (state_q == ST_SHIFT);
  assign done_o  = (state_q == ST_SHIFT) && div_end && (half_q == 6'd47);
  assign sync_o  = sync_q;
  assign sclk_o  = sclk_q;
  assign din_o   = din_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (state_q == ST_GAP) begin
          gap_d = gap_q + 1'b1;
          if (ready_o) state_d = ST_IDLE;
        end
        if (ready_o && start_i) begin
          state_d = ST_SHIFT;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          sh_d    = frame_i;
          din_d   = frame_i[FRAME_W-1];
          div_d   = '0;
          half_d  = '0;
        end
      end
      ST_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          if (half_q == 6'd47) begin
            state_d = ST_GAP;
            sync_d  = 1'b1;
            sclk_d  = 1'b1;
            din_d   = 1'b0;
            gap_d   = '0;
          end else begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
              din_d = sh_q[FRAME_W-2];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dac_ad56x4_multich_drv.sv
// ============================================================================
// Module   : dac_ad56x4_multich_drv
// Purpose  : Multi-channel AD56x4 SPI DAC driver: CSRs, sample hold, round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_ad56x4_multich_drv
  import dac_ad56x4_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SCLK_DIVIDER  = 2,
  parameter int SYNC_DURATION = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 avsAdr,
  input  logic                       avsWr,
  input  logic [15:0]                avsWrData,
  input  logic                       avsRd,
  output logic [15:0]                avsRdData,
  input  logic [N_CH-1:0]            asiValid,
  input  logic [N_CH*DATA_WIDTH-1:0] asiData,
  output logic [N_CH-1:0]            asiRdy,
  output logic                       dacSync,
  output logic                       dacSclk,
  output logic                       dacDin
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [1:0]            ctrl_q;
  logic [N_CH-1:0]       chen_q, signed_q, pending_q, pending_d, accept;
  logic [15:0]           frame_cnt_q, rd_data_q, rd_mux, data16;
  logic [DATA_WIDTH-1:0] hold_q [N_CH];
  logic [CH_W-1:0]       next_q, next_d, sel, idx;
  logic                  sel_vld, upd_q, upd_d, start;
  logic                  ser_ready, ser_busy, ser_done;
  logic [FRAME_W-1:0]    frame;
  logic                  unused_wr_bits;

  assign unused_wr_bits = ^avsWrData;
  assign asiRdy    = {N_CH{ctrl_q[0]}} & chen_q & ~pending_q;
  assign accept    = asiValid & asiRdy;
  assign avsRdData = rd_data_q;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_hold
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)         hold_q[i] <= '0;
        else if (accept[i]) hold_q[i] <= asiData[i*DATA_WIDTH +: DATA_WIDTH]
                                         ^ {signed_q[i], {(DATA_WIDTH-1){1'b0}}};
      end
    end
  endgenerate

  // next_q is where the search starts: one past the last channel served.
  always_comb begin
    sel     = '0;
    idx     = '0;
    sel_vld = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(next_q) + k) % N_CH);
      if (pending_q[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  assign start = ser_ready && ctrl_q[0] && (sel_vld || upd_q);

  always_comb begin
    data16 = 16'(hold_q[sel]) << (16 - DATA_WIDTH);
    if (sel_vld) frame = {2'b00, (ctrl_q[1] ? CMD_WR_IN : CMD_WR_UPD), 3'(sel), data16};
    else         frame = {2'b00, CMD_UPD, ADDR_ALL, 16'h0000};
  end

  always_comb begin
    pending_d = pending_q;
    next_d    = next_q;
    upd_d     = upd_q;
    if (start && sel_vld) begin
      next_d = (sel == CH_W'(N_CH - 1)) ? '0 : sel + 1'b1;
      if (ctrl_q[1]) upd_d = 1'b1;
    end else if (start) begin
      upd_d = 1'b0;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (start && sel_vld && (sel == CH_W'(i))) pending_d[i] = 1'b0;
      if (accept[i])                              pending_d[i] = 1'b1;
      if (!chen_q[i])                             pending_d[i] = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avsAdr)
      REG_CTRL:      rd_mux = {14'd0, ctrl_q};
      REG_CH_EN:     rd_mux = 16'(chen_q);
      REG_SIGNED:    rd_mux = 16'(signed_q);
      REG_STATUS:    rd_mux = (16'(pending_q) << 4) | {15'd0, ser_busy};
      REG_FRAME_CNT: rd_mux = frame_cnt_q;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q      <= '0;
      chen_q      <= '0;
      signed_q    <= '0;
      pending_q   <= '0;
      next_q      <= '0;
      upd_q       <= 1'b0;
      frame_cnt_q <= '0;
      rd_data_q   <= '0;
    end else begin
      pending_q <= pending_d;
      next_q    <= next_d;
      upd_q     <= upd_d;
      if (ser_done) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (avsRd)    rd_data_q   <= rd_mux;
      if (avsWr) begin
        case (avsAdr)
          REG_CTRL:   ctrl_q   <= avsWrData[1:0];
          REG_CH_EN:  chen_q   <= avsWrData[N_CH-1:0];
          REG_SIGNED: signed_q <= avsWrData[N_CH-1:0];
          default:    ;
        endcase
      end
    end
  end

  dac_spi_serializer #(
    .SCLK_DIVIDER  (SCLK_DIVIDER),
    .SYNC_DURATION (SYNC_DURATION)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .frame_i (frame),
    .ready_o (ser_ready),
    .busy_o  (ser_busy),
    .done_o  (ser_done),
    .sync_o  (dacSync),
    .sclk_o  (dacSclk),
    .din_o   (dacDin)
  );

endmodule

`default_nettype wire
